// File: rtl/dna_port_arbiter_if.sv
// Requester-side bus for the DNA port arbiter: per-requester req/ack
// handshake, cache flush, and the shared DNA result with its status flags.
interface dna_port_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] ack;
    logic               flush;
    logic               busy;
    logic               dna_valid;
    logic [63:0]        dna;

    // Requester view: drives requests and flush, observes the result.
    modport master (
        output req,
        output flush,
        input  ack,
        input  busy,
        input  dna_valid,
        input  dna
    );

    // Arbiter view: consumes requests and flush, returns the result.
    modport slave (
        input  req,
        input  flush,
        output ack,
        output busy,
        output dna_valid,
        output dna
    );
endinterface

// File: rtl/dna_port_arbiter.sv
// Owns the device DNA_PORT primitive. On a request with an empty cache it
// issues one READ cycle followed by DNA_BITS SHIFT cycles, assembles the
// serial stream MSB-first into a zero-extended 64-bit value and caches it.
// Requesters are served one at a time through a round-robin arbiter; a
// cached value is returned one cycle after the request is sampled.
module dna_port_arbiter #(
    parameter int DNA_BITS = 57,
    parameter int NUM_REQ  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dna_port_arbiter_if.slave    bus,
    output logic                 dnap_read,
    output logic                 dnap_shift,
    output logic                 dnap_din,
    input  logic                 dnap_dout
);

    // Pointer/grant width; a single requester still needs one bit.
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Bit counter wide enough to hold DNA_BITS-1 for up to 64 bits.
    localparam int CW = 7;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]         state_reg;
    logic [PW-1:0]      ptr_reg;
    logic [PW-1:0]      grant_reg;
    logic [CW-1:0]      count_reg;
    logic [63:0]        shreg_reg;
    logic [63:0]        dna_reg;
    logic               dna_valid_reg;
    logic               busy_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic               read_reg;
    logic               shift_en_reg;

    // Combinational arbitration results and ack decode.
    logic [NUM_REQ-1:0] hi_mask;
    logic [NUM_REQ-1:0] req_hi;
    logic [PW-1:0]      chain_hi  [0:NUM_REQ];
    logic [PW-1:0]      chain_all [0:NUM_REQ];
    logic [PW-1:0]      pick;
    logic               any_req;
    logic [NUM_REQ-1:0] ack_next;
    logic [63:0]        shreg_next;
    logic               last_bit;
    logic [PW-1:0]      ptr_next;

    // Round-robin search: requesters at or above the pointer take priority;
    // if none of those are requesting, the lowest requester overall wins,
    // which is the wrap-around part of the search. Each chain is a simple
    // lowest-index priority encoder built from the top down.
    assign chain_hi[NUM_REQ]  = '0;
    assign chain_all[NUM_REQ] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_arb
            assign hi_mask[gi]   = (ptr_reg <= PW'(gi));
            assign req_hi[gi]    = bus.req[gi] & hi_mask[gi];
            assign chain_hi[gi]  = req_hi[gi]  ? PW'(gi) : chain_hi[gi+1];
            assign chain_all[gi] = bus.req[gi] ? PW'(gi) : chain_all[gi+1];
            // Only the locked grant can be acknowledged, and only while its
            // requester is still asking; this also keeps ack one-hot.
            assign ack_next[gi]  = (state_reg == ST_DONE) &&
                                   (grant_reg == PW'(gi)) && bus.req[gi];
        end
    endgenerate

    assign any_req = |bus.req;
    assign pick    = (|req_hi) ? chain_hi[0] : chain_all[0];

    // Next shift-register value and end-of-read detection.
    assign shreg_next = {shreg_reg[62:0], dnap_dout};
    assign last_bit   = (count_reg == CW'(DNA_BITS - 1));

    // Pointer advances past the requester just served, wrapping at NUM_REQ.
    assign ptr_next = (grant_reg == PW'(NUM_REQ - 1)) ? '0 : grant_reg + PW'(1);

    // Main sequencer: arbitration, DNA_PORT protocol, cache and ack pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            ptr_reg       <= '0;
            grant_reg     <= '0;
            count_reg     <= '0;
            shreg_reg     <= '0;
            dna_reg       <= '0;
            dna_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            ack_reg       <= '0;
            read_reg      <= 1'b0;
            shift_en_reg  <= 1'b0;
        end else begin
            // Ack is a single-cycle pulse, only ever raised leaving DONE.
            ack_reg <= ack_next;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.flush) begin
                        dna_valid_reg <= 1'b0;
                    end
                    if (any_req) begin
                        grant_reg <= pick;
                        // A flush in the same cycle wins over a cache hit.
                        if (dna_valid_reg && !bus.flush) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg <= ST_LOAD;
                            read_reg  <= 1'b1;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // READ has been presented for one cycle; start shifting.
                    read_reg     <= 1'b0;
                    shift_en_reg <= 1'b1;
                    count_reg    <= '0;
                    shreg_reg    <= '0;
                    state_reg    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // Flush is ignored here: the value being read is fresh.
                    shreg_reg <= shreg_next;
                    if (last_bit) begin
                        dna_reg       <= shreg_next;
                        dna_valid_reg <= 1'b1;
                        shift_en_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_DONE;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.flush) begin
                        dna_valid_reg <= 1'b0;
                    end
                    ptr_reg   <= ptr_next;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack       = ack_reg;
    assign bus.busy      = busy_reg;
    assign bus.dna_valid = dna_valid_reg;
    assign bus.dna       = dna_reg;
    assign dnap_read     = read_reg;
    assign dnap_shift    = shift_en_reg;
    // DNA_PORT is only ever read, so nothing is rotated in.
    assign dnap_din      = 1'b0;

endmodule
